// File: rtl/arch_map_retire_pkg.sv
// Shared sizing, tag types and restore-walk state encoding for the retire-side
// architectural map table and its bypass helper.
package arch_map_retire_pkg;

  localparam int SIZE_LOGICAL      = 32;
  localparam int SIZE_LOGICAL_LOG  = 5;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int SIZE_PHYSICAL     = 1 << SIZE_PHYSICAL_LOG;
  localparam int COMMIT_WIDTH      = 4;

  typedef logic [SIZE_LOGICAL_LOG-1:0]  logIdx_t;
  typedef logic [SIZE_PHYSICAL_LOG-1:0] phyTag_t;

  localparam logic [0:0] WALK_IDLE = 1'b0;
  localparam logic [0:0] WALK_RUN  = 1'b1;

endpackage

// File: rtl/arch_map_retire_if.sv
// Commit, free-list and rename-map restore lanes between the retire pipeline
// (master) and the architectural map table (slave).
interface arch_map_retire_if;
  import arch_map_retire_pkg::*;

  logic [COMMIT_WIDTH-1:0] commitValid_i;
  logic [COMMIT_WIDTH-1:0] commitHasDest_i;
  logIdx_t [COMMIT_WIDTH-1:0] commitLogDest_i;
  phyTag_t [COMMIT_WIDTH-1:0] commitPhyDest_i;

  logic [COMMIT_WIDTH-1:0] freeValid_o;
  phyTag_t [COMMIT_WIDTH-1:0] freeReg_o;

  logic [COMMIT_WIDTH-1:0] rmtWrEn_o;
  logIdx_t [COMMIT_WIDTH-1:0] rmtWrAddr_o;
  phyTag_t [COMMIT_WIDTH-1:0] rmtWrData_o;

  modport master (
    output commitValid_i, commitHasDest_i, commitLogDest_i, commitPhyDest_i,
    input  freeValid_o, freeReg_o, rmtWrEn_o, rmtWrAddr_o, rmtWrData_o
  );

  modport slave (
    input  commitValid_i, commitHasDest_i, commitLogDest_i, commitPhyDest_i,
    output freeValid_o, freeReg_o, rmtWrEn_o, rmtWrAddr_o, rmtWrData_o
  );

endinterface

// File: rtl/arch_map_bypass.sv
// Intra-group forwarding for one commit group: previous mapping per lane and
// the youngest writer of each logical register.
module arch_map_bypass
  import arch_map_retire_pkg::*;
(
  input  logic [COMMIT_WIDTH-1:0]    laneActive_i,
  input  logIdx_t [COMMIT_WIDTH-1:0] logDest_i,
  input  phyTag_t [COMMIT_WIDTH-1:0] phyDest_i,
  input  phyTag_t [COMMIT_WIDTH-1:0] amtRd_i,
  output phyTag_t [COMMIT_WIDTH-1:0] oldMap_o,
  output logic [SIZE_LOGICAL-1:0]    logWrEn_o,
  output phyTag_t [SIZE_LOGICAL-1:0] logWrData_o
);

  // Later lanes overwrite earlier ones, so the youngest match always wins.
  always_comb begin
    oldMap_o    = amtRd_i;
    logWrEn_o   = '0;
    logWrData_o = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      for (int j = 0; j < k; j++) begin
        if (laneActive_i[j] && (logDest_i[j] == logDest_i[k])) begin
          oldMap_o[k] = phyDest_i[j];
        end
      end
      if (laneActive_i[k]) begin
        logWrEn_o[logDest_i[k]]   = 1'b1;
        logWrData_o[logDest_i[k]] = phyDest_i[k];
      end
    end
  end

endmodule

// File: rtl/arch_map_retire.sv
// Retire-side architectural map table: frees superseded tags and streams the
// map back to rename on recovery. Optional live-tag checker: AMT_FREE_CHECK_EN.
module arch_map_retire
  import arch_map_retire_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   recoverFlag_i,
  arch_map_retire_if.slave       amtIf,
  output logic                   restoreBusy_o,
  output logic                   amtError_o
);

  localparam logIdx_t LAST_IDX = logIdx_t'(SIZE_LOGICAL - COMMIT_WIDTH);

  phyTag_t [SIZE_LOGICAL-1:0] amt_q;
  logic [COMMIT_WIDTH-1:0]    laneActive;
  phyTag_t [COMMIT_WIDTH-1:0] amtRd;
  phyTag_t [COMMIT_WIDTH-1:0] oldMap;
  logic [SIZE_LOGICAL-1:0]    logWrEn;
  phyTag_t [SIZE_LOGICAL-1:0] logWrData;

  logic [COMMIT_WIDTH-1:0]    freeValid_q;
  phyTag_t [COMMIT_WIDTH-1:0] freeReg_q, freeReg_d;
  logic [0:0]                 state_q, state_d;
  logIdx_t                    idx_q, idx_d;

  assign laneActive = amtIf.commitValid_i & amtIf.commitHasDest_i;

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      amtRd[k] = amt_q[amtIf.commitLogDest_i[k]];
    end
  end

  arch_map_bypass uBypass (
    .laneActive_i (laneActive),
    .logDest_i    (amtIf.commitLogDest_i),
    .phyDest_i    (amtIf.commitPhyDest_i),
    .amtRd_i      (amtRd),
    .oldMap_o     (oldMap),
    .logWrEn_o    (logWrEn),
    .logWrData_o  (logWrData)
  );

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      freeReg_d[k] = laneActive[k] ? oldMap[k] : '0;
    end
  end

  // A new recover pulse always restarts from entry 0, even mid-walk.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (recoverFlag_i) begin
      state_d = WALK_RUN;
      idx_d   = '0;
    end else if (state_q == WALK_RUN) begin
      idx_d = idx_q + logIdx_t'(COMMIT_WIDTH);
      if (idx_q == LAST_IDX) begin
        state_d = WALK_IDLE;
        idx_d   = '0;
      end
    end
  end

  always_comb begin
    amtIf.rmtWrEn_o   = '0;
    amtIf.rmtWrAddr_o = '0;
    amtIf.rmtWrData_o = '0;
    if (state_q == WALK_RUN) begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        amtIf.rmtWrEn_o[k]   = 1'b1;
        amtIf.rmtWrAddr_o[k] = idx_q + logIdx_t'(k);
        amtIf.rmtWrData_o[k] = amt_q[idx_q + logIdx_t'(k)];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE_LOGICAL; i++) begin
        amt_q[i] <= phyTag_t'(i);
      end
      freeValid_q <= '0;
      freeReg_q   <= '0;
      state_q     <= WALK_IDLE;
      idx_q       <= '0;
    end else begin
      for (int i = 0; i < SIZE_LOGICAL; i++) begin
        if (logWrEn[i]) begin
          amt_q[i] <= logWrData[i];
        end
      end
      freeValid_q <= laneActive;
      freeReg_q   <= freeReg_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
    end
  end

  assign amtIf.freeValid_o = freeValid_q;
  assign amtIf.freeReg_o   = freeReg_q;
  assign restoreBusy_o     = (state_q == WALK_RUN);

`ifdef AMT_FREE_CHECK_EN
  logic [SIZE_PHYSICAL-1:0] live_q, live_d;
  logic                     amtError_q, errNow;

  // Lanes are applied in age order so a tag allocated and freed in one group
  // is seen as live by the younger lane.
  always_comb begin
    live_d = live_q;
    errNow = 1'b0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (laneActive[k]) begin
        if (!live_d[oldMap[k]]) errNow = 1'b1;
        live_d[oldMap[k]] = 1'b0;
        if (live_d[amtIf.commitPhyDest_i[k]]) errNow = 1'b1;
        live_d[amtIf.commitPhyDest_i[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SIZE_PHYSICAL; i++) begin
        live_q[i] <= (i < SIZE_LOGICAL);
      end
      amtError_q <= 1'b0;
    end else begin
      live_q     <= live_d;
      amtError_q <= amtError_q | errNow;
    end
  end

  assign amtError_o = amtError_q;
`else
  assign amtError_o = 1'b0;
`endif

endmodule

// File: tb/tb_arch_map_retire.sv
// Scoreboard bench for arch_map_retire: directed commits and recovery walks,
// expected free/restore records queued at issue and checked by monitors.
module tb_arch_map_retire;
  import arch_map_retire_pkg::*;

  typedef struct packed {
    logic [3:0]      fv;
    logic [3:0][6:0] fr;
  } freeRec_t;

  typedef struct packed {
    logic [3:0]      en;
    logic [3:0][4:0] addr;
    logic [3:0][6:0] data;
  } rmtRec_t;

  logic clk;
  logic reset_n;
  logic recoverFlag;
  logic restoreBusy;
  logic amtError;

  int checks = 0;
  int errors = 0;

  freeRec_t freeQ[$];
  rmtRec_t  rmtQ[$];
  logic [6:0] amtModel [SIZE_LOGICAL];

  arch_map_retire_if amtIf ();

  arch_map_retire dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .recoverFlag_i (recoverFlag),
    .amtIf         (amtIf.slave),
    .restoreBusy_o (restoreBusy),
    .amtError_o    (amtError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < SIZE_LOGICAL; i++) amtModel[i] = 7'(i);
  endtask

  task automatic clearInputs();
    amtIf.commitValid_i   = '0;
    amtIf.commitHasDest_i = '0;
    amtIf.commitLogDest_i = '0;
    amtIf.commitPhyDest_i = '0;
  endtask

  // Drives one commit group for a single clock and queues the hand-computed
  // free record it should produce one cycle later.
  task automatic applyStimulus(input logic [3:0] v, input logic [3:0] hd,
                               input logic [3:0][4:0] lg, input logic [3:0][6:0] ph,
                               input logic [3:0] efv, input logic [3:0][6:0] efr);
    freeRec_t rec;
    @(negedge clk);
    amtIf.commitValid_i   = v;
    amtIf.commitHasDest_i = hd;
    amtIf.commitLogDest_i = lg;
    amtIf.commitPhyDest_i = ph;
    rec.fv = efv;
    rec.fr = efr;
    freeQ.push_back(rec);
    for (int k = 0; k < 4; k++) begin
      if (v[k] && hd[k]) amtModel[lg[k]] = ph[k];
    end
    @(posedge clk);
    #1 clearInputs();
  endtask

  task automatic startRecover();
    rmtRec_t rec;
    @(negedge clk);
    recoverFlag = 1'b1;
    for (int w = 0; w < SIZE_LOGICAL / COMMIT_WIDTH; w++) begin
      rec.en = 4'hF;
      for (int k = 0; k < 4; k++) begin
        rec.addr[k] = 5'(w * 4 + k);
        rec.data[k] = amtModel[w * 4 + k];
      end
      rmtQ.push_back(rec);
    end
    @(posedge clk);
    #1 recoverFlag = 1'b0;
  endtask

  task automatic checkBusyWalk();
    for (int i = 0; i < SIZE_LOGICAL / COMMIT_WIDTH; i++) begin
      @(negedge clk);
      checkOutput($sformatf("restoreBusy_c%0d", i), 32'(restoreBusy), 32'd1);
    end
    @(negedge clk);
    checkOutput("restoreBusy_end", 32'(restoreBusy), 32'd0);
  endtask

  // Free-list monitor
  initial begin
    freeRec_t exp;
    forever begin
      @(negedge clk);
      if (reset_n && amtIf.freeValid_o != '0) begin
        if (freeQ.size() == 0) begin
          checkOutput("freeUnexpected", 32'(amtIf.freeValid_o), 32'd0);
        end else begin
          exp = freeQ.pop_front();
          checkOutput("freeValid", 32'(amtIf.freeValid_o), 32'(exp.fv));
          checkOutput("freeReg", 32'(amtIf.freeReg_o), 32'(exp.fr));
        end
      end
    end
  end

  // Restore-stream monitor
  initial begin
    rmtRec_t exp;
    forever begin
      @(negedge clk);
      if (reset_n && amtIf.rmtWrEn_o != '0) begin
        if (rmtQ.size() == 0) begin
          checkOutput("rmtUnexpected", 32'(amtIf.rmtWrEn_o), 32'd0);
        end else begin
          exp = rmtQ.pop_front();
          checkOutput("rmtWrEn", 32'(amtIf.rmtWrEn_o), 32'(exp.en));
          checkOutput("rmtWrAddr", 32'(amtIf.rmtWrAddr_o), 32'(exp.addr));
          checkOutput("rmtWrData", 32'(amtIf.rmtWrData_o), 32'(exp.data));
        end
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    recoverFlag = 1'b0;
    clearInputs();
    resetModel();
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    @(negedge clk);
    checkOutput("reset_restoreBusy", 32'(restoreBusy), 32'd0);
    checkOutput("reset_freeValid", 32'(amtIf.freeValid_o), 32'd0);
    checkOutput("reset_freeReg", 32'(amtIf.freeReg_o), 32'd0);
    checkOutput("reset_rmtWrEn", 32'(amtIf.rmtWrEn_o), 32'd0);
    checkOutput("reset_amtError", 32'(amtError), 32'd0);

    // lane0 3->40 frees 3
    applyStimulus(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {7'd0, 7'd0, 7'd0, 7'd40},
                  4'b0001, {7'd0, 7'd0, 7'd0, 7'd3});
    // lane0 5->50, lane2 5->52: lane2 frees the bypassed 50
    applyStimulus(4'b0101, 4'b0101, {5'd0, 5'd5, 5'd0, 5'd5}, {7'd0, 7'd52, 7'd0, 7'd50},
                  4'b0101, {7'd0, 7'd50, 7'd0, 7'd5});
    // lane1 valid without dest, lane3 7->60
    applyStimulus(4'b1010, 4'b1000, {5'd7, 5'd9, 5'd0, 5'd0}, {7'd60, 7'd99, 7'd0, 7'd0},
                  4'b1000, {7'd7, 7'd0, 7'd0, 7'd0});

    startRecover();
    checkBusyWalk();

    // all four lanes, two chained logical registers
    applyStimulus(4'b1111, 4'b1111, {5'd8, 5'd3, 5'd8, 5'd3}, {7'd44, 7'd43, 7'd42, 7'd41},
                  4'b1111, {7'd42, 7'd41, 7'd8, 7'd40});

    startRecover();
    checkBusyWalk();

    // reset during walk cycle 4
    startRecover();
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort_restoreBusy", 32'(restoreBusy), 32'd0);
    checkOutput("abort_rmtWrEn", 32'(amtIf.rmtWrEn_o), 32'd0);
    checkOutput("abort_freeValid", 32'(amtIf.freeValid_o), 32'd0);
    rmtQ.delete();
    resetModel();
    @(negedge clk) reset_n = 1'b1;

    // identity map after reset, including AMT[3]=3
    startRecover();
    checkBusyWalk();

    // log1 -> phy2 while phy2 is still architecturally live
    applyStimulus(4'b0001, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd1}, {7'd0, 7'd0, 7'd0, 7'd2},
                  4'b0001, {7'd0, 7'd0, 7'd0, 7'd1});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
`ifdef AMT_FREE_CHECK_EN
      checkOutput($sformatf("amtError_c%0d", i), 32'(amtError), 32'd1);
`else
      checkOutput($sformatf("amtError_c%0d", i), 32'(amtError), 32'd0);
`endif
    end

    repeat (3) @(negedge clk);
    checkOutput("freeQ_drained", 32'(freeQ.size()), 32'd0);
    checkOutput("rmtQ_drained", 32'(rmtQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arch_map_retire.md
Name: arch_map_retire

Overview:
- Retire-side architectural map table (AMT). It is the producer of the commitValid/commitReg stream consumed by the speculative free list.
- Per commit lane: records the new logical→physical mapping and releases the previous mapping to the free list.
- On a pipeline recovery it streams the AMT into the rename map table, several entries per cycle.

Parameters:
- SIZE_LOGICAL, 32, number of architectural registers.
- SIZE_LOGICAL_LOG, 5, log2 of SIZE_LOGICAL.
- SIZE_PHYSICAL_LOG, 7, physical tag width (128 physical registers).
- COMMIT_WIDTH, 4, commit lanes; also the number of restore entries emitted per cycle.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- recoverFlag_i  in  1  pulse: start an AMT restore walk.
- commitValid{k}_i  in  1  lane k retires this cycle (k=0..3, lane 0 oldest).
- commitHasDest{k}_i  in  1  lane k writes a destination register.
- commitLogDest{k}_i  in  SIZE_LOGICAL_LOG  logical destination.
- commitPhyDest{k}_i  in  SIZE_PHYSICAL_LOG  new physical mapping.
- freeValid{k}_o  out  1  feeds the free-list commitValid{k}.
- freeReg{k}_o  out  SIZE_PHYSICAL_LOG  released physical register.
- rmtWrEn{k}_o  out  1  restore write enable, slot k.
- rmtWrAddr{k}_o  out  SIZE_LOGICAL_LOG  restore logical index.
- rmtWrData{k}_o  out  SIZE_PHYSICAL_LOG  restore physical tag.
- restoreBusy_o  out  1  restore walk in progress; rename must stall.
- amtError_o  out  1  sticky consistency error (only with AMT_FREE_CHECK_EN, else tied 0).

Behaviour:
- Reset (async, reset_n=0): AMT[i]=i; all freeValid, rmtWrEn and restoreBusy outputs 0; freeReg/rmtWr* 0; walk IDLE; walk index 0; amtError 0.
- Lane k is active when commitValid{k}_i & commitHasDest{k}_i. Any valid-lane pattern is legal, including gaps.
- Old mapping of active lane k:
  - commitPhyDest of the youngest active lane j<k with the same logDest, if one exists;
  - otherwise AMT[logDest{k}] as it stood before this cycle.
- AMT update at clock edge: for each logical register, the youngest active lane writing it wins.
- Free outputs are registered, latency 1. In cycle t+1: freeValid{k}_o = lane k active at t, freeReg{k}_o = old mapping. Inactive lanes drive freeValid 0 and freeReg 0.
- Free outputs keep lane positions, so the free list compacts them.
- Restore FSM states: IDLE, WALK.
  - IDLE→WALK on recoverFlag_i; idx=0.
  - In WALK, each cycle: rmtWrEn{k}=1, rmtWrAddr{k}=idx+k, rmtWrData{k}=AMT[idx+k]; then idx += COMMIT_WIDTH.
  - WALK→IDLE after the slot carrying entry SIZE_LOGICAL-1. Walk takes SIZE_LOGICAL/COMMIT_WIDTH = 8 cycles.
  - restoreBusy_o=1 exactly while in WALK. rmt outputs are combinational from AMT and idx.
- Commits arriving in the same cycle as recoverFlag_i are applied before the walk's first read, so the walk reflects them.
- Commits during WALK are an upstream protocol error. The AMT still updates; already-emitted restore entries are not re-sent.
- recoverFlag_i during WALK restarts the walk at idx=0.
- Reset asserted mid-walk aborts to IDLE immediately.

Optional Feature:
- Macro AMT_FREE_CHECK_EN.
- With the macro: keep a SIZE_PHYSICAL-bit live vector, reset with bits 0..SIZE_LOGICAL-1 set.
  - Each active lane clears the bit of its freed register and sets the bit of its new phyDest.
  - amtError_o sets (sticky until reset) if a freed register's bit is already clear, or a new phyDest's bit is already set.
  - Intra-group bypass is applied before either check.
- Without the macro: no live vector; amtError_o is constant 0.

Decomposition:
- Shared package: SIZE_LOGICAL, SIZE_LOGICAL_LOG, SIZE_PHYSICAL_LOG, COMMIT_WIDTH, and the walk state encoding (IDLE=0, WALK=1).
- One sub-module: arch_map_bypass. Purely combinational: takes the 4 lanes plus 4 AMT read values and returns the 4 old mappings and per-logical youngest-writer enables.

Test Plan:
- Reset, then lane0 commit log 3→phy 40 → next cycle freeValid0=1, freeReg0=3; AMT[3]=40.
- Same cycle: lane0 log 5→50, lane2 log 5→52 → freeReg0=5, freeReg2=50; AMT[5]=52; freeValid1=freeValid3=0.
- Lane1 valid with commitHasDest=0 plus lane3 log 7→60 → only freeValid3=1 with freeReg3=7.
- After AMT[3]=40, pulse recoverFlag_i → 8 busy cycles; in cycle 0, rmtWrAddr3=3 with rmtWrData3=40; restoreBusy falls after 8 cycles.
- Drop reset_n during walk cycle 4 → restoreBusy_o=0 immediately; AMT[3]=3.
- With AMT_FREE_CHECK_EN: commit log 1→phy 2 (phy 2 still live) → amtError_o=1 and stays high; without the macro it stays 0.
